// File: rtl/l_transform_seq.sv
// Iterative Kuznyechik linear layer: sixteen R (or R^-1) byte-LFSR steps,
// one step per clock, on a single 128-bit working register.
//
// Ports:
//   clk      clock; all state updates on its rising edge
//   rst      synchronous reset, active low
//   valid_i  upstream offers a block on data_i
//   inv_i    0 = forward L, 1 = inverse L^-1 (latched on accept)
//   data_i   input block, byte a15 = [127:120], byte a0 = [7:0]
//   ready_o  block can be accepted (IDLE only)
//   valid_o  data_o holds a finished result (DONE)
//   data_o   working register, same byte order as data_i
//   ready_i  downstream takes data_o
//   busy_o   transform in progress (RUN)
module l_transform_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic         inv_i,
    input  logic [127:0] data_i,
    output logic         ready_o,
    output logic         valid_o,
    output logic [127:0] data_o,
    input  logic         ready_i,
    output logic         busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // l() weights, byte-aligned: the weight of a_i sits at [8*i +: 8]
    localparam logic [127:0] L_COEF =
        128'h94_20_85_10_C2_C0_01_FB_01_C0_C2_10_85_20_94_01;

    state_t       state_q, state_d;
    logic [127:0] work_q, work_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         inv_q, inv_d;

    logic [127:0] rot;
    logic [127:0] r_fwd;
    logic [127:0] r_inv;

    // GF(2^8) multiply modulo x^8+x^7+x^6+x+1; b is always a constant
    // weight here, so this folds into a small XOR network.
    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'hC3) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    function automatic logic [7:0] l_func(input logic [127:0] a);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            acc = acc ^ gf_mul(a[8*i +: 8], L_COEF[8*i +: 8]);
        end
        return acc;
    endfunction

    // R: new byte enters at the top, everything shifts down one byte.
    assign r_fwd = {l_func(work_q), work_q[127:8]};

    // R^-1 feeds l() with (a14..a0, a15), which is the register
    // rotated left by one byte; new byte enters at the bottom.
    assign rot   = {work_q[119:0], work_q[127:120]};
    assign r_inv = {work_q[119:0], l_func(rot)};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    work_d  = data_i;
                    inv_d   = inv_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                work_d = inv_q ? r_inv : r_fwd;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = DONE;
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == RUN);
    assign valid_o = (state_q == DONE);
    assign data_o  = work_q;

endmodule

// File: tb/tb_l_transform_seq.sv
// Self-checking bench for l_transform_seq: known vectors, random blocks
// against a byte-level L/L^-1 model, reset, backpressure and throughput.
module tb_l_transform_seq;

    logic         clk;
    logic         rst;
    logic         valid_i;
    logic         inv_i;
    logic [127:0] data_i;
    logic         ready_o;
    logic         valid_o;
    logic [127:0] data_o;
    logic         ready_i;
    logic         busy_o;

    l_transform_seq dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .inv_i   (inv_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .ready_i (ready_i),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 16 RUN cycles, one DONE cycle, one IDLE cycle before the next accept
    localparam int LATENCY  = 16;
    localparam int INTERVAL = LATENCY + 2;

    // weights of l() listed for a15 first down to a0
    localparam int COEF [16] = '{148, 32, 133, 16, 194, 192, 1, 251,
                                 1, 192, 194, 16, 133, 32, 148, 1};

    int n_chk;
    int n_fail;
    int cyc;
    int vcount;
    int acc_q[$];
    logic [127:0] res_q[$];

    typedef struct {
        string        name;
        logic         inv;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t vecs[3];

    always @(posedge clk) begin
        if (rst && valid_i && ready_o) acc_q.push_back(cyc);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (valid_o) vcount++;
        if (valid_o && ready_i) res_q.push_back(data_o);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] mdl_mul(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) != 0) p = p ^ (a << i);
        for (int k = 14; k >= 8; k--)
            if (((p >> k) & 1) != 0) p = p ^ ('h1C3 << (k - 8));
        return 8'(p);
    endfunction

    function automatic logic [127:0] model_l(
        input logic         inv,
        input logic [127:0] din
    );
        logic [7:0] b[16];
        logic [7:0] s;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = din[8*i +: 8];
        for (int step = 0; step < 16; step++) begin
            s = 8'h00;
            if (!inv) begin
                for (int i = 0; i < 16; i++)
                    s = s ^ mdl_mul(int'(b[i]), COEF[15 - i]);
                for (int i = 0; i < 15; i++) b[i] = b[i + 1];
                b[15] = s;
            end else begin
                for (int k = 0; k < 15; k++)
                    s = s ^ mdl_mul(int'(b[14 - k]), COEF[k]);
                s = s ^ mdl_mul(int'(b[15]), COEF[15]);
                for (int i = 15; i > 0; i--) b[i] = b[i - 1];
                b[0] = s;
            end
        end
        for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(
        input string        nm,
        input logic [127:0] got,
        input logic [127:0] exp
    );
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the accept edge.
    task automatic start_block(input logic inv, input logic [127:0] din);
        bit got;
        valid_i = 1'b1;
        inv_i   = inv;
        data_i  = din;
        got     = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_o) begin
                got = 1'b1;
                break;
            end
        end
        chk("accept_timeout", 128'(got), 128'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        inv_i   = ~inv;
        data_i  = rnd128();
        chk("busy_in_run", 128'(busy_o), 128'd1);
        chk("ready_in_run", 128'(ready_o), 128'd0);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) begin
                n = i;
                break;
            end
        end
        chk({nm, "_latency"}, 128'(n), 128'(LATENCY));
    endtask

    task automatic take_result();
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        chk("idle_ready", 128'(ready_o), 128'd1);
        chk("idle_valid", 128'(valid_o), 128'd0);
    endtask

    task automatic run_block(
        input  string        nm,
        input  logic         inv,
        input  logic [127:0] din,
        output logic [127:0] dout
    );
        start_block(inv, din);
        wait_done(nm);
        dout = data_o;
        take_result();
    endtask

    initial begin
        logic [127:0] d;
        logic [127:0] hold;
        logic [127:0] blk[3];
        logic         binv[3];
        int           vsnap;
        bit           got;

        n_chk   = 0;
        n_fail  = 0;
        cyc     = 0;
        vcount  = 0;

        vecs[0] = '{"fwd_vec", 1'b0,
                    128'h64a59400000000000000000000000000,
                    128'hd456584dd0e3e84cc3166e4b7fa2890d};
        vecs[1] = '{"chain_vec", 1'b0,
                    128'hd456584dd0e3e84cc3166e4b7fa2890d,
                    128'h79d26221b87b584cd42fbc4ffea5de9a};
        vecs[2] = '{"inv_vec", 1'b1,
                    128'hd456584dd0e3e84cc3166e4b7fa2890d,
                    128'h64a59400000000000000000000000000};

        // reset with valid_i asserted: no accept may happen
        rst     = 1'b0;
        valid_i = 1'b1;
        inv_i   = 1'b1;
        data_i  = rnd128();
        ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 128'(ready_o), 128'd1);
        chk("rst_valid", 128'(valid_o), 128'd0);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_data", data_o, 128'd0);
        valid_i = 1'b0;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_busy", 128'(busy_o), 128'd0);

        // known vectors
        for (int i = 0; i < 3; i++) begin
            run_block(vecs[i].name, vecs[i].inv, vecs[i].din, d);
            chk(vecs[i].name, d, vecs[i].dout);
        end

        // random blocks against the model, both directions
        for (int i = 0; i < 4; i++) begin
            blk[0]  = rnd128();
            binv[0] = 1'($urandom_range(0, 1));
            run_block("rand", binv[0], blk[0], d);
            chk("rand_data", d, model_l(binv[0], blk[0]));
        end

        // single R step, then reset mid-run
        start_block(1'b0, 128'h00000000000000000000000000000100);
        @(posedge clk);
        #1;
        chk("one_step", data_o, 128'h94000000000000000000000000000001);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk("midrun_rst_data", data_o, 128'd0);
        chk("midrun_rst_valid", 128'(valid_o), 128'd0);
        chk("midrun_rst_ready", 128'(ready_o), 128'd1);
        vsnap = vcount;
        repeat (30) @(posedge clk);
        #1;
        chk("no_valid_after_rst", 128'(vcount), 128'(vsnap));

        // backpressure in DONE; valid_i toggling there has no effect
        blk[0] = rnd128();
        start_block(1'b1, blk[0]);
        wait_done("bp");
        hold    = data_o;
        valid_i = 1'b1;
        inv_i   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            ready_i = 1'b0;
            @(posedge clk);
            #1;
            chk("bp_data", data_o, hold);
            chk("bp_valid", 128'(valid_o), 128'd1);
            chk("bp_ready", 128'(ready_o), 128'd0);
        end
        chk("bp_result", hold, model_l(1'b1, blk[0]));
        valid_i = 1'b0;
        take_result();

        // back-to-back throughput
        acc_q.delete();
        res_q.delete();
        for (int k = 0; k < 3; k++) begin
            blk[k]  = rnd128();
            binv[k] = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
        valid_i = 1'b1;
        data_i  = blk[0];
        inv_i   = binv[0];
        for (int k = 0; k < 3; k++) begin
            got = 1'b0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (ready_o) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("tp_accept_timeout", 128'(got), 128'd1);
            @(posedge clk);
            #1;
            if (k < 2) begin
                data_i = blk[k + 1];
                inv_i  = binv[k + 1];
            end
        end
        for (int i = 0; i < 60; i++) begin
            if (res_q.size() >= 3) break;
            @(posedge clk);
        end
        #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        chk("tp_accepts", 128'(acc_q.size()), 128'd3);
        chk("tp_results", 128'(res_q.size()), 128'd3);
        if (acc_q.size() >= 3) begin
            chk("tp_gap0", 128'(acc_q[1] - acc_q[0]), 128'(INTERVAL));
            chk("tp_gap1", 128'(acc_q[2] - acc_q[1]), 128'(INTERVAL));
        end
        for (int k = 0; k < 3; k++) begin
            if (k < res_q.size())
                chk("tp_data", res_q[k], model_l(binv[k], blk[k]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
